// File: rtl/writeback.sv
// writeback: final pipeline stage. Turns up to two register writes per
// instruction into a stream of single register-file writes, redirects
// writes to r15 onto jmp/jmppc, and owns the architectural CPSR/SPSR.
// Optional feature: define WRITEBACK_SPSR_EN to build the SPSR register;
// otherwise spsr reads as constant 0 and the SPSR inputs are ignored.
//
// Stall handshake: outstall is combinational from state and current
// inputs. While outstall=1 the upstream stage keeps presenting the same
// instruction on the next cycle. That repeated copy arrives in WB_SECOND
// and is dropped, because its writes are already held or issued.
module writeback (
    input  logic        clk,
    input  logic        Nrst,
    input  logic        inbubble,
    input  logic [31:0] inpc,
    input  logic        wr1_en,
    input  logic [3:0]  wr1_num,
    input  logic [31:0] wr1_data,
    input  logic        wr2_en,
    input  logic [3:0]  wr2_num,
    input  logic [31:0] wr2_data,
    input  logic        cpsr_wr,
    input  logic [31:0] cpsr_data,
    input  logic        spsr_wr,
    input  logic [31:0] spsr_data,
    output logic        outstall,
    output logic        rf_we,
    output logic [3:0]  rf_num,
    output logic [31:0] rf_data,
    output logic [31:0] cpsr,
    output logic [31:0] spsr,
    output logic        jmp,
    output logic [31:0] jmppc
);

    typedef enum logic {
        WB_IDLE   = 1'b0,
        WB_SECOND = 1'b1
    } wb_state_t;

    localparam logic [3:0]  PC_REG     = 4'd15;
    localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

    wb_state_t   r_state;
    wb_state_t   w_next_state;
    logic [3:0]  r_hold_num;
    logic [31:0] r_hold_data;
    logic        r_rf_we;
    logic [3:0]  r_rf_num;
    logic [31:0] r_rf_data;
    logic        r_jmp;
    logic [31:0] r_jmppc;
    logic [31:0] r_cpsr;

    logic        w_valid;
    logic        w_issue;
    logic [3:0]  w_issue_num;
    logic [31:0] w_issue_data;
    logic        w_hold_load;
    logic        w_stall;
    logic        w_issue_pc;

    // A new instruction is only accepted in WB_IDLE.
    assign w_valid    = (r_state == WB_IDLE) && !inbubble;
    assign w_issue_pc = (w_issue_num == PC_REG);

    // Next-state and write selection: pick the write issued at the coming
    // edge, decide whether wr1 must be parked, and raise the stall.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_issue_num  = r_hold_num;
        w_issue_data = r_hold_data;
        w_hold_load  = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            WB_IDLE: begin
                if (!inbubble) begin
                    if (wr1_en && wr2_en && (wr1_num != wr2_num)) begin
                        // Base writeback goes first, load/ALU result is parked.
                        w_issue      = 1'b1;
                        w_issue_num  = wr2_num;
                        w_issue_data = wr2_data;
                        w_hold_load  = 1'b1;
                        w_stall      = 1'b1;
                        w_next_state = WB_SECOND;
                    end else if (wr1_en) begin
                        // Covers the same-register dual case: wr1 wins.
                        w_issue      = 1'b1;
                        w_issue_num  = wr1_num;
                        w_issue_data = wr1_data;
                    end else if (wr2_en) begin
                        w_issue      = 1'b1;
                        w_issue_num  = wr2_num;
                        w_issue_data = wr2_data;
                    end
                end
            end
            WB_SECOND: begin
                // Drain the parked wr1; the repeated inputs are ignored.
                w_issue      = 1'b1;
                w_issue_num  = r_hold_num;
                w_issue_data = r_hold_data;
                w_next_state = WB_IDLE;
            end
            default: begin
                w_next_state = WB_IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is asserted.
    assign outstall = w_stall && Nrst;

    // State register.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Hold register for the deferred wr1 of a dual write.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_hold_num  <= 4'd0;
            r_hold_data <= 32'd0;
        end else if (w_hold_load) begin
            r_hold_num  <= wr1_num;
            r_hold_data <= wr1_data;
        end
    end

    // Register-file port: one write per cycle, never for r15.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_rf_we   <= 1'b0;
            r_rf_num  <= 4'd0;
            r_rf_data <= 32'd0;
        end else if (w_issue && !w_issue_pc) begin
            r_rf_we   <= 1'b1;
            r_rf_num  <= w_issue_num;
            r_rf_data <= w_issue_data;
        end else begin
            r_rf_we   <= 1'b0;
        end
    end

    // Redirect pulse: a write to r15 becomes a one-cycle jump.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_jmp   <= 1'b0;
            r_jmppc <= 32'd0;
        end else if (w_issue && w_issue_pc) begin
            r_jmp   <= 1'b1;
            r_jmppc <= w_issue_data;
        end else begin
            r_jmp   <= 1'b0;
        end
    end

    // CPSR updates once, on the accepting WB_IDLE cycle only.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_cpsr <= CPSR_RESET;
        end else if (w_valid && cpsr_wr) begin
            r_cpsr <= cpsr_data;
        end
    end

`ifdef WRITEBACK_SPSR_EN
    logic [31:0] r_spsr;
    logic        w_unused;

    // SPSR updates under the same rule as CPSR.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_spsr <= 32'd0;
        end else if (w_valid && spsr_wr) begin
            r_spsr <= spsr_data;
        end
    end

    assign spsr     = r_spsr;
    assign w_unused = ^inpc;
`else
    logic w_unused;

    assign spsr     = 32'd0;
    assign w_unused = ^{inpc, spsr_wr, spsr_data};
`endif

    assign rf_we   = r_rf_we;
    assign rf_num  = r_rf_num;
    assign rf_data = r_rf_data;
    assign jmp     = r_jmp;
    assign jmppc   = r_jmppc;
    assign cpsr    = r_cpsr;

endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed bench for writeback. The reference model treats
// each accepted instruction as an ordered list of writes that drain one
// per clock; registered outputs and the stall are compared every cycle.
module tb_writeback;

    logic        clk;
    logic        Nrst;
    logic        inbubble;
    logic [31:0] inpc;
    logic        wr1_en;
    logic [3:0]  wr1_num;
    logic [31:0] wr1_data;
    logic        wr2_en;
    logic [3:0]  wr2_num;
    logic [31:0] wr2_data;
    logic        cpsr_wr;
    logic [31:0] cpsr_data;
    logic        spsr_wr;
    logic [31:0] spsr_data;
    logic        outstall;
    logic        rf_we;
    logic [3:0]  rf_num;
    logic [31:0] rf_data;
    logic [31:0] cpsr;
    logic [31:0] spsr;
    logic        jmp;
    logic [31:0] jmppc;

    writeback dut (
        .clk       (clk),
        .Nrst      (Nrst),
        .inbubble  (inbubble),
        .inpc      (inpc),
        .wr1_en    (wr1_en),
        .wr1_num   (wr1_num),
        .wr1_data  (wr1_data),
        .wr2_en    (wr2_en),
        .wr2_num   (wr2_num),
        .wr2_data  (wr2_data),
        .cpsr_wr   (cpsr_wr),
        .cpsr_data (cpsr_data),
        .spsr_wr   (spsr_wr),
        .spsr_data (spsr_data),
        .outstall  (outstall),
        .rf_we     (rf_we),
        .rf_num    (rf_num),
        .rf_data   (rf_data),
        .cpsr      (cpsr),
        .spsr      (spsr),
        .jmp       (jmp),
        .jmppc     (jmppc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model state ----------------
    logic [35:0] exp_q[$];        // pending writes {num, data}, oldest first
    logic        exp_stall;
    logic        exp_rf_we;
    logic [3:0]  exp_rf_num;
    logic [31:0] exp_rf_data;
    logic        exp_jmp;
    logic [31:0] exp_jmppc;
    logic [31:0] exp_cpsr;
    logic [31:0] exp_spsr;
    logic        chk_en;
    logic        stall_seen;
    int          n_chk;
    int          n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("outstall", {31'd0, outstall}, {31'd0, exp_stall});
            check("rf_we", {31'd0, rf_we}, {31'd0, exp_rf_we});
            if (exp_rf_we) begin
                check("rf_num", {28'd0, rf_num}, {28'd0, exp_rf_num});
                check("rf_data", rf_data, exp_rf_data);
            end
            check("jmp", {31'd0, jmp}, {31'd0, exp_jmp});
            if (exp_jmp) check("jmppc", jmppc, exp_jmppc);
            check("cpsr", cpsr, exp_cpsr);
            check("spsr", spsr, exp_spsr);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        inbubble  = 1'b1;
        inpc      = 32'd0;
        wr1_en    = 1'b0;
        wr1_num   = 4'd0;
        wr1_data  = 32'd0;
        wr2_en    = 1'b0;
        wr2_num   = 4'd0;
        wr2_data  = 32'd0;
        cpsr_wr   = 1'b0;
        cpsr_data = 32'd0;
        spsr_wr   = 1'b0;
        spsr_data = 32'd0;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input logic bub,
                        input logic w1e, input logic [3:0] w1n, input logic [31:0] w1d,
                        input logic w2e, input logic [3:0] w2n, input logic [31:0] w2d,
                        input logic cw, input logic [31:0] cd,
                        input logic sw, input logic [31:0] sd);
        logic [35:0] wr;
        logic        has_wr;
        logic [31:0] nxt_cpsr;
        logic [31:0] nxt_spsr;
        inbubble  = bub;
        inpc      = inpc + 32'd4;
        wr1_en    = w1e;
        wr1_num   = w1n;
        wr1_data  = w1d;
        wr2_en    = w2e;
        wr2_num   = w2n;
        wr2_data  = w2d;
        cpsr_wr   = cw;
        cpsr_data = cd;
        spsr_wr   = sw;
        spsr_data = sd;
        has_wr   = 1'b0;
        wr       = 36'd0;
        nxt_cpsr = exp_cpsr;
        nxt_spsr = exp_spsr;
        if (exp_q.size() > 0) begin
            // Busy draining: this cycle's inputs are a repeat and are dropped.
            wr        = exp_q.pop_front();
            has_wr    = 1'b1;
            exp_stall = 1'b0;
        end else if (!bub) begin
            if (w1e && w2e && (w1n != w2n)) begin
                exp_q.push_back({w2n, w2d});
                exp_q.push_back({w1n, w1d});
            end else if (w1e) begin
                exp_q.push_back({w1n, w1d});
            end else if (w2e) begin
                exp_q.push_back({w2n, w2d});
            end
            exp_stall = (exp_q.size() > 1);
            if (exp_q.size() > 0) begin
                wr     = exp_q.pop_front();
                has_wr = 1'b1;
            end
            if (cw) nxt_cpsr = cd;
`ifdef WRITEBACK_SPSR_EN
            if (sw) nxt_spsr = sd;
`endif
        end else begin
            exp_stall = 1'b0;
        end
        @(negedge clk);
        stall_seen = outstall;
        @(posedge clk);
        exp_rf_we = has_wr && (wr[35:32] != 4'd15);
        exp_jmp   = has_wr && (wr[35:32] == 4'd15);
        if (exp_rf_we) begin
            exp_rf_num  = wr[35:32];
            exp_rf_data = wr[31:0];
        end
        if (exp_jmp) exp_jmppc = wr[31:0];
        exp_cpsr = nxt_cpsr;
        exp_spsr = nxt_spsr;
        #1;
    endtask

    task automatic bubble();
        step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    // Asserts reset mid-cycle with a dual write on the inputs, holds it
    // across one full clock, then releases just after a rising edge.
    task automatic reset_seq();
        inbubble = 1'b0;
        wr1_en   = 1'b1;
        wr1_num  = 4'd1;
        wr1_data = 32'h0000_0A0A;
        wr2_en   = 1'b1;
        wr2_num  = 4'd9;
        wr2_data = 32'h0000_0B0B;
        cpsr_wr  = 1'b1;
        cpsr_data = 32'h0000_0011;
        Nrst = 1'b0;
        #1;
        exp_q.delete();
        exp_stall   = 1'b0;
        exp_rf_we   = 1'b0;
        exp_rf_num  = 4'd0;
        exp_rf_data = 32'd0;
        exp_jmp     = 1'b0;
        exp_jmppc   = 32'd0;
        exp_cpsr    = 32'h0000_00D3;
        exp_spsr    = 32'd0;
        chk_en      = 1'b1;
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_rf_num", {28'd0, rf_num}, 32'd0);
        check("rst_rf_data", rf_data, 32'd0);
        check("rst_jmp", {31'd0, jmp}, 32'd0);
        check("rst_jmppc", jmppc, 32'd0);
        check("rst_cpsr", cpsr, 32'h0000_00D3);
        check("rst_spsr", spsr, 32'd0);
        check("rst_outstall", {31'd0, outstall}, 32'd0);
        @(posedge clk);
        #1;
        set_idle();
        Nrst = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_chk  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        stall_seen = 1'b0;
        exp_stall = 1'b0;
        exp_rf_we = 1'b0;
        exp_rf_num = 4'd0;
        exp_rf_data = 32'd0;
        exp_jmp = 1'b0;
        exp_jmppc = 32'd0;
        exp_cpsr = 32'h0000_00D3;
        exp_spsr = 32'd0;
        set_idle();
        Nrst = 1'b0;
        @(posedge clk);
        #1;
        reset_seq();
        bubble();

        // Single write r3
        step(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("single_stall", {31'd0, stall_seen}, 32'd0);
        check("single_we", {31'd0, rf_we}, 32'd1);
        check("single_num", {28'd0, rf_num}, 32'd3);
        check("single_data", rf_data, 32'hDEAD_BEEF);
        bubble();
        check("idle_we", {31'd0, rf_we}, 32'd0);

        // Dual write r2/r5: r5 first, stall, then r2 (inputs held upstream)
        step(1'b0, 1'b1, 4'd2, 32'h11, 1'b1, 4'd5, 32'h22, 1'b0, 32'd0, 1'b0, 32'd0);
        check("dual_stall", {31'd0, stall_seen}, 32'd1);
        check("dual_num1", {28'd0, rf_num}, 32'd5);
        check("dual_data1", rf_data, 32'h22);
        step(1'b0, 1'b1, 4'd2, 32'h11, 1'b1, 4'd5, 32'h22, 1'b0, 32'd0, 1'b0, 32'd0);
        check("dual2_stall", {31'd0, stall_seen}, 32'd0);
        check("dual_we2", {31'd0, rf_we}, 32'd1);
        check("dual_num2", {28'd0, rf_num}, 32'd2);
        check("dual_data2", rf_data, 32'h11);
        bubble();

        // Same-register dual: wr1 wins, no stall
        step(1'b0, 1'b1, 4'd4, 32'hAA, 1'b1, 4'd4, 32'hBB, 1'b0, 32'd0, 1'b0, 32'd0);
        check("same_stall", {31'd0, stall_seen}, 32'd0);
        check("same_data", rf_data, 32'hAA);
        bubble();
        check("same_once", {31'd0, rf_we}, 32'd0);

        // PC write
        step(1'b0, 1'b1, 4'd15, 32'h0000_0100, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("pc_we", {31'd0, rf_we}, 32'd0);
        check("pc_jmp", {31'd0, jmp}, 32'd1);
        check("pc_jmppc", jmppc, 32'h0000_0100);
        bubble();
        check("pc_pulse", {31'd0, jmp}, 32'd0);

        // wr2 only
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h66, 1'b0, 32'd0, 1'b0, 32'd0);

        // Dual with held wr1 to r15, plus CPSR/SPSR writes applied once
        step(1'b0, 1'b1, 4'd15, 32'h200, 1'b1, 4'd3, 32'h33, 1'b1, 32'h1F, 1'b1, 32'h55);
        check("cpsr_wr", cpsr, 32'h0000_001F);
        step(1'b0, 1'b1, 4'd15, 32'h200, 1'b1, 4'd3, 32'h33, 1'b1, 32'h10, 1'b1, 32'h77);
        check("held_jmp", {31'd0, jmp}, 32'd1);
        check("held_jmppc", jmppc, 32'h200);
        check("cpsr_once", cpsr, 32'h0000_001F);

        // Bubble with every request set: nothing happens
        step(1'b1, 1'b1, 4'd7, 32'h7, 1'b1, 4'd15, 32'h8, 1'b1, 32'h12, 1'b1, 32'h13);
        check("bub_we", {31'd0, rf_we}, 32'd0);
        check("bub_cpsr", cpsr, 32'h0000_001F);

        // Back-to-back mix from a compact table
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i % 3) != 2, 4'(i + 1), 32'h1000 + 32'(i),
                 (i % 2) == 0, 4'((i * 5) % 16), 32'h2000 + 32'(i),
                 (i % 4) == 1, 32'h0000_0040 + 32'(i), 1'b0, 32'd0);
        end
        bubble();

        // Reset during WB_SECOND abandons the held write
        step(1'b0, 1'b1, 4'd2, 32'h11, 1'b1, 4'd5, 32'h22, 1'b0, 32'd0, 1'b0, 32'd0);
        reset_seq();
        bubble();
        check("abandon_we", {31'd0, rf_we}, 32'd0);
        check("abandon_cpsr", cpsr, 32'h0000_00D3);
        step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'h10, 1'b0, 32'd0);
        check("bub_cpsr_wr", cpsr, 32'h0000_00D3);
        bubble();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
